// File: rtl/ascii_char_fifo.sv
// Byte-wide valid/ready FIFO with first-word fall-through and a saturating lowercase counter.
// Optional build macro NONPRINT_DROP_EN: accepts but discards non-printable bytes other than LF.
module ascii_char_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  lc_count
);

  localparam logic [ADDR_W:0]  FullLevel = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [CNT_W-1:0]  lc_count_q, lc_count_d;

  logic push, pop, keep, store, is_lower;

  assign in_ready  = (level_q != FullLevel);
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign lc_count  = lc_count_q;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign is_lower = (in_data >= 8'h61) && (in_data <= 8'h7A);

`ifdef NONPRINT_DROP_EN
  // Dropped bytes still complete the handshake; they just never reach storage.
  assign keep = ((in_data >= 8'h20) && (in_data <= 8'h7E)) || (in_data == 8'h0A);
`else
  assign keep = 1'b1;
`endif

  assign store = push & keep;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(store);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    level_d    = level_q + (ADDR_W + 1)'(store) - (ADDR_W + 1)'(pop);
    lc_count_d = lc_count_q;
    if (push && is_lower && (lc_count_q != CntMax)) begin
      lc_count_d = lc_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      lc_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      lc_count_q <= lc_count_d;
    end
  end

  // Storage is deliberately not reset; level gates every read.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_ascii_char_fifo.sv
// Self-checking bench for ascii_char_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_ascii_char_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 5;  // small so saturation is reached by random traffic
  localparam int LC_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [ADDR_W:0]   level;
  logic [CNT_W-1:0]  lc_count;

  ascii_char_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .lc_count  (lc_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int peak  = 0;

  logic [7:0] mq[$];
  int         lc_ref = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit keeps(input logic [7:0] d);
`ifdef NONPRINT_DROP_EN
    return ((d >= 8'h20) && (d <= 8'h7E)) || (d == 8'h0A);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_all();
    chk("level", 32'(level), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("lc_count", 32'(lc_count), 32'(lc_ref));
    if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
  endtask

  // One clock: predict handshakes from current inputs, advance, then compare.
  task automatic tick();
    bit         exp_push, exp_pop;
    logic [7:0] d;
    exp_push = in_valid && (mq.size() < DEPTH);
    exp_pop  = out_ready && (mq.size() > 0);
    d        = in_data;
    @(posedge clk);
    #1;
    if (exp_pop) void'(mq.pop_front());
    if (exp_push) begin
      if (d >= 8'h61 && d <= 8'h7A && lc_ref < LC_MAX) lc_ref++;
      if (keeps(d)) mq.push_back(d);
    end
    if (mq.size() > peak) peak = mq.size();
    check_all();
  endtask

  task automatic push_one(input logic [7:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] s6 [3];
    int         exp_peak;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // 1: "a","B","z" with the consumer stalled
    push_one(8'h61);
    push_one(8'h42);
    push_one(8'h7A);
    chk("t1_level", 32'(level), 32'd3);
    chk("t1_head", 32'(out_data), 32'h61);
    chk("t1_lc", 32'(lc_count), 32'd2);

    // 2: pop all three in order
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    chk("t2_out_valid", 32'(out_valid), 32'd0);
    chk("t2_level", 32'(level), 32'd0);

    // 3: fill, hold a 9th byte, free one slot, then drain across the wrap
    for (int i = 0; i < DEPTH; i++) push_one(8'(8'h30 + i));
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h38;
    tick();
    chk("t3_held_level", 32'(level), 32'd8);
    out_ready = 1'b1;
    tick();
    chk("t3_after_pop_level", 32'(level), 32'd7);
    out_ready = 1'b0;
    tick();
    chk("t3_accepted_level", 32'(level), 32'd8);
    drain();

    // 4: steady push+pop at level 4
    for (int i = 0; i < 4; i++) push_one(8'(8'h41 + i));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h20 + $urandom_range(0, 94));
      tick();
      chk("t4_level", 32'(level), 32'd4);
    end
    drain();

    // 5: asynchronous reset with five bytes queued
    for (int i = 0; i < 5; i++) push_one(8'(8'h61 + i));
    in_valid = 1'b1;
    in_data  = 8'h66;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    lc_ref = 0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_lc", 32'(lc_count), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();

    // 6: BEL, LF, 'A'
    s6[0] = 8'h07;
    s6[1] = 8'h0A;
    s6[2] = 8'h41;
    peak = 0;
    for (int i = 0; i < 3; i++) push_one(s6[i]);
`ifdef NONPRINT_DROP_EN
    exp_peak = 2;
    chk("t6_head", 32'(out_data), 32'h0A);
`else
    exp_peak = 3;
    chk("t6_head", 32'(out_data), 32'h07);
`endif
    chk("t6_peak", 32'(peak), 32'(exp_peak));
    drain();

    // Random traffic; in_data held while stalled
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = ($urandom_range(0, 1) == 1) ? 8'(8'h61 + $urandom_range(0, 25))
                                               : 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    chk("lc_saturated", 32'(lc_count), 32'(LC_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
